// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and constants for the ALU writeback stage: default widths,
// status-flag bit positions and the buffered result record.
package alu_writeback_stage_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_RADDR_W = 4;

  localparam int unsigned FLAG_Z  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_C  = 2;
  localparam int unsigned FLAG_V  = 3;
  localparam int unsigned FLAG_LT = 4;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]  result;
    logic                   cout;
    logic                   ov;
    logic                   lt;
    logic [DEF_RADDR_W-1:0] rd;
    logic                   we;
    logic                   setf;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-result handshake and register-file write port bundle.
// master = ALU / register-file side, slave = writeback stage.
interface alu_writeback_stage_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_result;
  logic               in_cout;
  logic               in_ov;
  logic               in_lt;
  logic [RADDR_W-1:0] in_rd;
  logic               in_we;
  logic               in_setf;
  logic               wb_ready;
  logic               wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;

  modport master (
    output in_valid, in_result, in_cout, in_ov, in_lt, in_rd, in_we, in_setf, wb_ready,
    input  in_ready, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_ov, in_lt, in_rd, in_we, in_setf, wb_ready,
    output in_ready, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_writeback_stage_wb_skid_buffer.sv
// Two-entry in-order FIFO holding pending ALU results.
// ALU_WB_FWD_EN adds o_next (entry behind the head) for operand forwarding.
module wb_skid_buffer
  import alu_writeback_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  logic      i_pop,
  input  wb_entry_t i_entry,
  output wb_entry_t o_head,
`ifdef ALU_WB_FWD_EN
  output wb_entry_t o_next,
`endif
  output logic [1:0] o_count
);

  wb_entry_t  r_mem [2];
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_wr_ptr;

  // Tail slot sits just behind the head when one entry is already held.
  assign w_wr_ptr = r_rd_ptr ^ (r_count == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (i_push) begin
        r_mem[w_wr_ptr] <= i_entry;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
`ifdef ALU_WB_FWD_EN
  assign o_next  = r_mem[~r_rd_ptr];
`endif
  assign o_count = r_count;

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage: buffers ALU results, retires them in order to the
// register-file port and keeps the status flags. ALU_WB_FWD_EN adds bypass outputs.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RADDR_W = DEF_RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_writeback_stage_if.slave bus,
  output logic [4:0]           flags,
  output logic                 busy
`ifdef ALU_WB_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [RADDR_W-1:0]   fwd_addr,
  output logic [DATA_W-1:0]    fwd_data
`endif
);

  wb_entry_t  w_in_entry;
  wb_entry_t  w_head;
  logic [1:0] w_count;
  logic       w_push;
  logic       w_pop;
  logic [4:0] r_flags;
  logic [4:0] w_head_flags;
`ifdef ALU_WB_FWD_EN
  wb_entry_t  w_next;
`endif

  assign w_in_entry = '{result: bus.in_result, cout: bus.in_cout, ov: bus.in_ov,
                        lt: bus.in_lt, rd: bus.in_rd, we: bus.in_we, setf: bus.in_setf};

  assign bus.in_ready = !rst && (w_count != 2'd2);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = !rst && (w_count != 2'd0) && bus.wb_ready;

  wb_skid_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_in_entry),
    .o_head  (w_head),
`ifdef ALU_WB_FWD_EN
    .o_next  (w_next),
`endif
    .o_count (w_count)
  );

  assign bus.wb_en   = w_pop && w_head.we;
  assign bus.wb_addr = (w_count != 2'd0) ? w_head.rd     : '0;
  assign bus.wb_data = (w_count != 2'd0) ? w_head.result : '0;
  assign busy        = (w_count != 2'd0);

  always_comb begin
    w_head_flags          = '0;
    w_head_flags[FLAG_Z]  = (w_head.result == '0);
    w_head_flags[FLAG_N]  = w_head.result[DATA_W-1];
    w_head_flags[FLAG_C]  = w_head.cout;
    w_head_flags[FLAG_V]  = w_head.ov;
    w_head_flags[FLAG_LT] = w_head.lt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_pop && w_head.setf) begin
      r_flags <= w_head_flags;
    end
  end

  assign flags = r_flags;

`ifdef ALU_WB_FWD_EN
  // Younger (tail) entry wins so the bypass always carries the newest value.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (!rst) begin
      if ((w_count == 2'd2) && w_next.we) begin
        fwd_valid = 1'b1;
        fwd_addr  = w_next.rd;
        fwd_data  = w_next.result;
      end else if ((w_count != 2'd0) && w_head.we) begin
        fwd_valid = 1'b1;
        fwd_addr  = w_head.rd;
        fwd_data  = w_head.result;
      end
    end
  end
`endif

endmodule
